proc_sys_reset_seq: RTL and testbench
=====================================

# proc_sys_reset_seq

Parametrised, sequenced system reset generator on `slowest_sync_clk`. It merges the external, auxiliary, debug and clock-lock reset sources into one reset condition. Asynchronous sources pass through synchronisers, and the block holds reset for a programmable time after the last source clears. It then releases the reset domains in a fixed order (bus/interconnect, then peripherals, then processor), so each domain leaves reset only after the fabric it depends on. It sits at the root of the processor subsystem reset tree and drives multi-channel reset vectors with correct per-output polarity.

## Interface
- `NUM_BUS`, 1: width of `bus_struct_reset`.
- `NUM_INTERCONNECT`, 1: width of `interconnect_aresetn`.
- `NUM_PERIPH`, 1: width of `peripheral_reset` and `peripheral_aresetn`.
- `HOLD_CYCLES`, 16: cycles reset is held after all sources clear; must be ≥1.
- `STAGE_GAP`, 4: cycles between successive release stages; must be ≥1.
- `AUX_ACTIVE_HIGH`, 1: polarity of `aux_reset_in`; 1 = active-high, 0 = active-low.
- `slowest_sync_clk`  in  1  sole clock; all logic is on its rising edge.
- `ext_reset_in`  in  1  synchronous, active-high reset; already synchronous to `slowest_sync_clk`, not resynchronised.
- `aux_reset_in`  in  1  asynchronous auxiliary reset; polarity set by `AUX_ACTIVE_HIGH`.
- `mb_debug_sys_rst`  in  1  asynchronous debug system reset, active-high.
- `dcm_locked`  in  1  asynchronous clock-lock indication; low = reset source active.
- `mb_reset`  out  1  processor reset, active-high.
- `bus_struct_reset`  out  `NUM_BUS`  bus reset, active-high.
- `interconnect_aresetn`  out  `NUM_INTERCONNECT`  interconnect reset, active-low.
- `peripheral_reset`  out  `NUM_PERIPH`  peripheral reset, active-high.
- `peripheral_aresetn`  out  `NUM_PERIPH`  peripheral reset, active-low.
- `seq_done`  out  1  high only in state RUN.

## Operation
- `aux_reset_in`, `mb_debug_sys_rst` and `dcm_locked` each pass through a 2-flop synchroniser.
- `ext_reset_in` = 1 clears all synchroniser flops to 0. For `dcm_locked` this reads as unlocked. For `aux_reset_in` with `AUX_ACTIVE_HIGH` = 0, the flops take the inactive value 1.
- `src_active` = synchronised aux active OR synchronised debug OR NOT synchronised lock.
- Every output is a registered function of the next state. All bits of a vector always move together.
- States and transitions:
  - **ASSERT**: all resets asserted (`mb_reset`, `bus_struct_reset`, `peripheral_reset` = 1; both `*_aresetn` = 0); `seq_done` = 0. Leaves to HOLD when `src_active` = 0, with counter cleared.
  - **HOLD**: resets still asserted; counter increments each cycle. Goes to STAGE1 on the cycle the counter reaches `HOLD_CYCLES`−1.
  - **STAGE1**: `bus_struct_reset` = 0 and `interconnect_aresetn` = all-1 are released. Goes to STAGE2 after `STAGE_GAP` cycles.
  - **STAGE2**: additionally `peripheral_reset` = 0 and `peripheral_aresetn` = all-1 are released. Goes to RUN after `STAGE_GAP` cycles.
  - **RUN**: additionally `mb_reset` = 0; `seq_done` = 1.
- `ext_reset_in` = 1 or `src_active` = 1 in any state forces ASSERT on that edge with counter = 0. This has priority over every other transition.
- A re-entry to ASSERT always restarts the full sequence; there is no partial release.
- Counter width is `$clog2(max(HOLD_CYCLES,STAGE_GAP)+1)`. It is cleared on every state change and never wraps.

## Timing
- Reset values (edge with `ext_reset_in` = 1): state ASSERT; `mb_reset` = 1; `bus_struct_reset` = all-1; `peripheral_reset` = all-1; `interconnect_aresetn` = 0; `peripheral_aresetn` = 0; `seq_done` = 0.
- Assertion latency:
  - `ext_reset_in`: outputs asserted at the first edge it is sampled high.
  - Asynchronous sources: outputs asserted at the third edge (s+2) after the source is first sampled active at edge s.
- Release timing, with `ext_reset_in` first sampled low at edge k and the other sources quiet with lock high:
  - HOLD entered at k+2 (synchroniser fill).
  - Bus/interconnect released at k+2+`HOLD_CYCLES`.
  - Peripherals released at k+2+`HOLD_CYCLES`+`STAGE_GAP`.
  - `mb_reset` released and `seq_done` high at k+2+`HOLD_CYCLES`+2·`STAGE_GAP`.
- Simultaneous events: a source going active on the same edge as a stage transition yields ASSERT, not the next stage.

## Configuration
- `PSR_RESET_CAUSE_EN` defined:
  - Adds output `reset_cause` [3:0] = {ext, aux, debug, lock_lost}.
  - Each bit sets when its source forces ASSERT; the bits are sticky.
  - All bits clear to 0 on the edge STAGE1 is entered, except `ext` (bit 3), which is set while `ext_reset_in` = 1 and also clears on entry to STAGE1.
- Undefined: the port and logic are absent; all other behaviour is identical.

## Test plan
- Power-up with `HOLD_CYCLES` = 16, `STAGE_GAP` = 4, `NUM_PERIPH` = 3: `ext_reset_in` high for 5 cycles, low at edge k → bus released at k+18, `peripheral_aresetn` = 3'b111 at k+22, `mb_reset` = 0 and `seq_done` = 1 at k+26.
- In RUN, `dcm_locked` low for 1 cycle sampled at edge s → all outputs asserted at s+2, then full re-sequence from HOLD.
- In STAGE2, pulse `mb_debug_sys_rst` → `peripheral_reset` reasserted to 3'b111, state returns to ASSERT, `seq_done` stays 0 until re-release.
- `AUX_ACTIVE_HIGH` = 0, `aux_reset_in` = 0 held for 40 cycles → outputs remain asserted for the whole 40 cycles. Release follows `HOLD_CYCLES` + 2·`STAGE_GAP` after synchroniser fill.
- `ext_reset_in` asserted mid-HOLD (counter = 9) → ASSERT on that edge; after release, HOLD lasts the full 16 cycles, not 7.
- With `PSR_RESET_CAUSE_EN`: lock loss followed by debug reset → `reset_cause` = 4'b0011 during ASSERT, 4'b0000 after STAGE1 entry.

Source files
------------

// File: rtl/proc_sys_reset_seq.sv
// Sequenced system reset generator: bus/interconnect, then peripherals, then processor.
// Optional PSR_RESET_CAUSE_EN adds a sticky reset_cause[3:0] = {ext, aux, debug, lock_lost}.
module proc_sys_reset_seq #(
    parameter int NUM_BUS          = 1,
    parameter int NUM_INTERCONNECT = 1,
    parameter int NUM_PERIPH       = 1,
    parameter int HOLD_CYCLES      = 16,
    parameter int STAGE_GAP        = 4,
    parameter int AUX_ACTIVE_HIGH  = 1
) (
    input  logic                        slowest_sync_clk,
    input  logic                        ext_reset_in,
    input  logic                        aux_reset_in,
    input  logic                        mb_debug_sys_rst,
    input  logic                        dcm_locked,
    output logic                        mb_reset,
    output logic [NUM_BUS-1:0]          bus_struct_reset,
    output logic [NUM_INTERCONNECT-1:0] interconnect_aresetn,
    output logic [NUM_PERIPH-1:0]       peripheral_reset,
    output logic [NUM_PERIPH-1:0]       peripheral_aresetn,
`ifdef PSR_RESET_CAUSE_EN
    output logic [3:0]                  reset_cause,
`endif
    output logic                        seq_done
);

    localparam int MAXC = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic AUX_IDLE = (AUX_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_HOLD,
        ST_STAGE1,
        ST_STAGE2,
        ST_RUN
    } state_t;

    logic [1:0]    r_aux_s;
    logic [1:0]    r_dbg_s;
    logic [1:0]    r_lock_s;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_aux_act;
    logic          w_dbg_act;
    logic          w_lock_lost;
    logic          w_src_active;
    logic          r_mb;
    logic          r_bus;
    logic          r_per;
    logic          r_done;

    always_ff @(posedge slowest_sync_clk) begin
        if (ext_reset_in) begin
            r_aux_s  <= {2{AUX_IDLE}};
            r_dbg_s  <= 2'b00;
            r_lock_s <= 2'b00;
        end else begin
            r_aux_s  <= {r_aux_s[0], aux_reset_in};
            r_dbg_s  <= {r_dbg_s[0], mb_debug_sys_rst};
            r_lock_s <= {r_lock_s[0], dcm_locked};
        end
    end

    assign w_aux_act    = (r_aux_s[1] != AUX_IDLE);
    assign w_dbg_act    = r_dbg_s[1];
    assign w_lock_lost  = ~r_lock_s[1];
    assign w_src_active = w_aux_act | w_dbg_act | w_lock_lost;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (ext_reset_in || w_src_active) begin
            w_state_nxt = ST_ASSERT;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                ST_ASSERT: begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                end
                ST_HOLD: begin
                    if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
                        w_state_nxt = ST_STAGE1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                ST_STAGE1: begin
                    if (r_cnt == CW'(STAGE_GAP - 1)) begin
                        w_state_nxt = ST_STAGE2;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                ST_STAGE2: begin
                    if (r_cnt == CW'(STAGE_GAP - 1)) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                ST_RUN: begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end
                default: begin
                    w_state_nxt = ST_ASSERT;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they change on the transition edge.
    always_ff @(posedge slowest_sync_clk) begin
        if (ext_reset_in) begin
            r_state <= ST_ASSERT;
            r_cnt   <= '0;
            r_mb    <= 1'b1;
            r_bus   <= 1'b1;
            r_per   <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mb    <= (w_state_nxt != ST_RUN);
            r_bus   <= (w_state_nxt == ST_ASSERT) || (w_state_nxt == ST_HOLD);
            r_per   <= (w_state_nxt == ST_ASSERT) || (w_state_nxt == ST_HOLD)
                    || (w_state_nxt == ST_STAGE1);
            r_done  <= (w_state_nxt == ST_RUN);
        end
    end

    assign mb_reset             = r_mb;
    assign bus_struct_reset     = {NUM_BUS{r_bus}};
    assign interconnect_aresetn = {NUM_INTERCONNECT{~r_bus}};
    assign peripheral_reset     = {NUM_PERIPH{r_per}};
    assign peripheral_aresetn   = {NUM_PERIPH{~r_per}};
    assign seq_done             = r_done;

`ifdef PSR_RESET_CAUSE_EN
    logic [3:0] r_cause;

    always_ff @(posedge slowest_sync_clk) begin
        if (ext_reset_in) begin
            r_cause <= r_cause | {1'b1, w_aux_act, w_dbg_act, w_lock_lost};
        end else if (r_state == ST_HOLD && w_state_nxt == ST_STAGE1) begin
            r_cause <= 4'b0000;
        end else begin
            r_cause <= r_cause | {1'b0, w_aux_act, w_dbg_act, w_lock_lost};
        end
    end

    assign reset_cause = r_cause;
`endif

endmodule

// File: tb/tb_proc_sys_reset_seq.sv
// Randomised bench for proc_sys_reset_seq against a quiet-time reference model.
module tb_proc_sys_reset_seq;

    localparam int NB = 2;
    localparam int NI = 2;
    localparam int NP = 3;
    localparam int H  = 16;
    localparam int G  = 4;
    localparam int AH = 0;

    logic          clk = 1'b0;
    logic          ext = 1'b1;
    logic          aux = 1'b1;
    logic          dbg = 1'b0;
    logic          lock = 1'b1;
    logic          mb_reset;
    logic [NB-1:0] bus_struct_reset;
    logic [NI-1:0] interconnect_aresetn;
    logic [NP-1:0] peripheral_reset;
    logic [NP-1:0] peripheral_aresetn;
    logic          seq_done;
`ifdef PSR_RESET_CAUSE_EN
    logic [3:0]    reset_cause;
`endif

    always #5 clk = ~clk;

    proc_sys_reset_seq #(
        .NUM_BUS(NB), .NUM_INTERCONNECT(NI), .NUM_PERIPH(NP),
        .HOLD_CYCLES(H), .STAGE_GAP(G), .AUX_ACTIVE_HIGH(AH)
    ) dut (
        .slowest_sync_clk(clk),
        .ext_reset_in(ext),
        .aux_reset_in(aux),
        .mb_debug_sys_rst(dbg),
        .dcm_locked(lock),
        .mb_reset(mb_reset),
        .bus_struct_reset(bus_struct_reset),
        .interconnect_aresetn(interconnect_aresetn),
        .peripheral_reset(peripheral_reset),
        .peripheral_aresetn(peripheral_aresetn),
`ifdef PSR_RESET_CAUSE_EN
        .reset_cause(reset_cause),
`endif
        .seq_done(seq_done)
    );

    int n_cmp = 0;
    int n_err = 0;
    int edge_no = 0;
    int q = 0;
    logic [1:0] h_ext = 2'b11;
    logic [1:0] h_aux = 2'b00;
    logic [1:0] h_dbg = 2'b00;
    logic [1:0] h_ll  = 2'b11;
    logic [3:0] m_cause = 4'b0000;
    bit         cause_ok = 1'b0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at edge %0d",
                     tag, got, exp, edge_no);
        end
    endtask

    // Model: quiet time q since the last edge where any synchronised source
    // (or ext) was active decides which domains are out of reset.
    task automatic cyc();
        logic cl, a_act, d_act, ll, forced;
        @(posedge clk);
        edge_no++;
        cl     = h_ext[0] | h_ext[1];
        a_act  = cl ? 1'b0 : h_aux[1];
        d_act  = cl ? 1'b0 : h_dbg[1];
        ll     = cl ? 1'b1 : h_ll[1];
        forced = ext | a_act | d_act | ll;
        q      = forced ? 0 : ((q < 100000) ? q + 1 : q);
        if (!forced && q == 1 + H) begin
            m_cause  = 4'b0000;
            cause_ok = 1'b1;
        end else begin
            m_cause = m_cause | {ext, a_act, d_act, ll};
        end
        h_ext = {h_ext[0], ext};
        h_aux = {h_aux[0], (aux == 1'(AH))};
        h_dbg = {h_dbg[0], dbg};
        h_ll  = {h_ll[0], ~lock};
        @(negedge clk);
        chk("mb_reset", 32'(mb_reset), (q < 1 + H + 2 * G) ? 32'd1 : 32'd0);
        chk("seq_done", 32'(seq_done), (q >= 1 + H + 2 * G) ? 32'd1 : 32'd0);
        chk("bus_struct_reset", 32'(bus_struct_reset),
            (q < 1 + H) ? 32'((1 << NB) - 1) : 32'd0);
        chk("interconnect_aresetn", 32'(interconnect_aresetn),
            (q < 1 + H) ? 32'd0 : 32'((1 << NI) - 1));
        chk("peripheral_reset", 32'(peripheral_reset),
            (q < 1 + H + G) ? 32'((1 << NP) - 1) : 32'd0);
        chk("peripheral_aresetn", 32'(peripheral_aresetn),
            (q < 1 + H + G) ? 32'd0 : 32'((1 << NP) - 1));
`ifdef PSR_RESET_CAUSE_EN
        if (cause_ok) chk("reset_cause", 32'(reset_cause), 32'(m_cause));
`endif
    endtask

    initial begin
        int k;
        int t;
        @(negedge clk);
        // power-up release latency
        ext = 1'b1;
        repeat (5) cyc();
        ext = 1'b0;
        k = edge_no + 1;
        t = 0;
        do begin
            cyc();
            t++;
        end while (!seq_done && t < 100);
        chk("release_latency", 32'(edge_no - k), 32'(2 + H + 2 * G));

        // one-cycle lock loss while running
        lock = 1'b0;
        cyc();
        lock = 1'b1;
        cyc();
        chk("lock_pre_assert", 32'(mb_reset), 32'd0);
        cyc();
        chk("lock_assert", 32'(mb_reset), 32'd1);
        repeat (30) cyc();

        // debug pulse during STAGE2
        ext = 1'b1;
        cyc();
        ext = 1'b0;
        repeat (2 + H + G + 1) cyc();
        chk("in_stage2", 32'(peripheral_reset), 32'd0);
        dbg = 1'b1;
        cyc();
        dbg = 1'b0;
        repeat (2) cyc();
        chk("dbg_periph", 32'(peripheral_reset), 32'b111);
        chk("dbg_done", 32'(seq_done), 32'd0);
        repeat (35) cyc();

        // active-low aux held for 40 cycles
        aux = 1'b0;
        repeat (40) cyc();
        aux = 1'b1;
        repeat (40) cyc();

        // ext during HOLD restarts the full hold
        ext = 1'b1;
        cyc();
        ext = 1'b0;
        repeat (2 + 10) cyc();
        ext = 1'b1;
        cyc();
        chk("ext_midhold", 32'(bus_struct_reset), 32'((1 << NB) - 1));
        ext = 1'b0;
        repeat (2 + H - 1) cyc();
        chk("full_hold", 32'(bus_struct_reset), 32'((1 << NB) - 1));
        repeat (30) cyc();

        // randomised source bursts
        repeat (60) begin
            int kind;
            kind = $urandom_range(0, 3);
            unique case (kind)
                0: ext = 1'b1;
                1: aux = 1'b0;
                2: dbg = 1'b1;
                default: lock = 1'b0;
            endcase
            repeat ($urandom_range(1, 3)) cyc();
            ext = 1'b0;
            aux = 1'b1;
            dbg = 1'b0;
            lock = 1'b1;
            repeat ($urandom_range(3, 35)) cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
